// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// =====================================================================
// Module   : axi4_lite_reg_slave
// Purpose  : AXI4-Lite slave terminating into N_REGS registers of 8*N bits.
//            Define AXI4_LITE_REG_SLAVE_ERR_EN for range check + SLVERR.
// Revision : 1.0
// =====================================================================
module axi4_lite_reg_slave #(
   parameter int A      = 32,
   parameter int N      = 4,
   parameter int N_REGS = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [A-1:0]            awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [8*N-1:0]          wdata,
   input  logic [N-1:0]            wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [A-1:0]            araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [8*N-1:0]          rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [N_REGS*8*N-1:0]   reg_out,
   output logic [N_REGS-1:0]       wr_pulse
);

   localparam int         c_DW   = 8 * N;
   localparam int         c_LB   = $clog2(N);
   localparam int         c_IB   = $clog2(N_REGS);
   localparam logic [1:0] c_OKAY = 2'b00;

   logic                rdy_q;
   logic                aw_held_q, aw_held_d;
   logic [A-1:0]        aw_addr_q, aw_addr_d;
   logic                w_held_q, w_held_d;
   logic [c_DW-1:0]     w_data_q, w_data_d;
   logic [N-1:0]        w_strb_q, w_strb_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [N_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic                rvalid_q, rvalid_d;
   logic [c_DW-1:0]     rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [c_DW-1:0]     regs_q [N_REGS];
   logic [c_DW-1:0]     regs_d [N_REGS];

   logic                w_aw_fire, w_w_fire, w_ar_fire, w_do_write;
   logic [A-1:0]        w_aw_addr;
   logic [c_DW-1:0]     w_wdata;
   logic [N-1:0]        w_wstrb;
   logic [c_IB-1:0]     w_widx, w_ridx;
   logic                w_wr_ok, w_rd_ok;
   logic [1:0]          w_wr_resp, w_rd_resp;
   logic                w_unused;

   // rdy_q keeps every ready low until the first edge after reset release
   assign awready = rdy_q & ~aw_held_q & ~bvalid_q;
   assign wready  = rdy_q & ~w_held_q & ~bvalid_q;
   assign arready = rdy_q & ~rvalid_q;

   assign w_aw_fire  = awvalid & awready;
   assign w_w_fire   = wvalid & wready;
   assign w_ar_fire  = arvalid & arready;
   assign w_do_write = (aw_held_q | w_aw_fire) & (w_held_q | w_w_fire);

   assign w_aw_addr = aw_held_q ? aw_addr_q : awaddr;
   assign w_wdata   = w_held_q ? w_data_q : wdata;
   assign w_wstrb   = w_held_q ? w_strb_q : wstrb;
   assign w_widx    = w_aw_addr[c_LB +: c_IB];
   assign w_ridx    = araddr[c_LB +: c_IB];
   assign w_unused  = ^{w_aw_addr, araddr};

`ifdef AXI4_LITE_REG_SLAVE_ERR_EN
   localparam logic [1:0] c_SLVERR = 2'b10;
   assign w_wr_ok   = (w_aw_addr >> (c_LB + c_IB)) == '0;
   assign w_rd_ok   = (araddr >> (c_LB + c_IB)) == '0;
   assign w_wr_resp = w_wr_ok ? c_OKAY : c_SLVERR;
   assign w_rd_resp = w_rd_ok ? c_OKAY : c_SLVERR;
`else
   assign w_wr_ok   = 1'b1;
   assign w_rd_ok   = 1'b1;
   assign w_wr_resp = c_OKAY;
   assign w_rd_resp = c_OKAY;
`endif

   always_comb begin
      aw_held_d  = aw_held_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;

      if (bvalid_q && bready)
         bvalid_d = 1'b0;

      if (w_do_write) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = w_wr_resp;
         if (w_wr_ok) begin
            wr_pulse_d[w_widx] = 1'b1;
            for (int b = 0; b < N; b++)
               if (w_wstrb[b])
                  regs_d[w_widx][b*8 +: 8] = w_wdata[b*8 +: 8];
         end
      end else begin
         if (w_aw_fire) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr;
         end
         if (w_w_fire) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
         end
      end

      if (rvalid_q && rready)
         rvalid_d = 1'b0;

      // Reads sample regs_q, so a same-edge write is not yet visible
      if (w_ar_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = w_rd_ok ? regs_q[w_ridx] : '0;
         rresp_d  = w_rd_resp;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rdy_q      <= 1'b0;
         aw_held_q  <= 1'b0;
         aw_addr_q  <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         wr_pulse_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         regs_q     <= '{default: '0};
      end else begin
         rdy_q      <= 1'b1;
         aw_held_q  <= aw_held_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         regs_q     <= regs_d;
      end
   end

   assign bvalid   = bvalid_q;
   assign bresp    = bresp_q;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;
   assign rresp    = rresp_q;
   assign wr_pulse = wr_pulse_q;

   for (genvar k = 0; k < N_REGS; k++) begin : g_reg_out
      assign reg_out[k*c_DW +: c_DW] = regs_q[k];
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
`default_nettype none
// =====================================================================
// Module   : tb_axi4_lite_reg_slave
// Purpose  : Self-checking bench for axi4_lite_reg_slave (A=32, N=4, N_REGS=16).
// Revision : 1.0
// =====================================================================
module tb_axi4_lite_reg_slave;

   logic          aclk = 1'b0;
   logic          areset;
   logic [31:0]   awaddr, araddr, wdata, rdata;
   logic [3:0]    wstrb;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [1:0]    bresp, rresp;
   logic [511:0]  reg_out;
   logic [15:0]   wr_pulse;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   model [16];

   axi4_lite_reg_slave #(.A(32), .N(4), .N_REGS(16)) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Register window is 16 regs * 4 bytes = 64 bytes starting at 0
   function automatic bit m_ok(input logic [31:0] a);
`ifdef AXI4_LITE_REG_SLAVE_ERR_EN
      return a < 32'd64;
`else
      return 1'b1;
`endif
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a % 64) / 4);
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly,
                           input int w_dly, input int b_dly);
      bit aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs, ok;
      int cyc = 0, idx;
      ok  = m_ok(addr);
      idx = m_idx(addr);
      awaddr = addr; wdata = data; wstrb = strb;
      while ((aw_pend || w_pend) && cyc < 40) begin
         awvalid = aw_pend && (cyc >= aw_dly);
         wvalid  = w_pend && (cyc >= w_dly);
         if (!aw_pend && w_pend) chk("aw_held_awready", awready, 0);
         if (aw_pend && !w_pend) chk("w_held_wready", wready, 0);
         if (aw_pend || w_pend)  chk("no_early_bvalid", bvalid, 0);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         if (aw_hs) aw_pend = 1'b0;
         if (w_hs)  w_pend = 1'b0;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_timeout", aw_pend || w_pend, 0);
      chk("bvalid", bvalid, 1);
      chk("bresp", bresp, ok ? 2'b00 : 2'b10);
      chk("wr_pulse", wr_pulse, ok ? (16'h1 << idx) : 16'h0);
      if (ok)
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      chk("reg_after_wr", reg_out[idx*32 +: 32], model[idx]);
      for (int i = 0; i < b_dly; i++) begin
         tick();
         chk("bvalid_hold", bvalid, 1);
         chk("bresp_hold", bresp, ok ? 2'b00 : 2'b10);
         chk("awready_bhold", awready, 0);
         chk("wready_bhold", wready, 0);
         chk("wr_pulse_once", wr_pulse, 0);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("bvalid_drop", bvalid, 0);
      chk("awready_back", awready, 1);
      chk("wready_back", wready, 1);
      chk("wr_pulse_clear", wr_pulse, 0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      bit pend = 1'b1, hs, ok;
      int cyc = 0;
      logic [31:0] exp_d;
      ok    = m_ok(addr);
      exp_d = ok ? model[m_idx(addr)] : 32'h0;
      araddr = addr;
      while (pend && cyc < 40) begin
         arvalid = pend && (cyc >= ar_dly);
         hs = arvalid && arready;
         tick();
         if (hs) pend = 1'b0;
         cyc++;
      end
      arvalid = 1'b0;
      chk("rd_timeout", pend, 0);
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, exp_d);
      chk("rresp", rresp, ok ? 2'b00 : 2'b10);
      chk("arready_busy", arready, 0);
      for (int i = 0; i < r_dly; i++) begin
         tick();
         chk("rvalid_hold", rvalid, 1);
         chk("rdata_hold", rdata, exp_d);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rvalid_drop", rvalid, 0);
      chk("arready_back", arready, 1);
   endtask

   initial begin
      logic [31:0] a;
      areset = 1'b0;
      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0;
      for (int i = 0; i < 16; i++) model[i] = '0;

      #2 areset = 1'b1;
      #1;
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_resp", {bresp, rresp}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_wr_pulse", wr_pulse, 0);
      chk("rst_regs_zero", reg_out == '0, 1);
      repeat (2) tick();
      chk("rst_hold_awready", awready, 0);
      areset = 1'b0;
      #1;
      chk("pre_edge_arready", arready, 0);
      tick();
      chk("post_rst_awready", awready, 1);
      chk("post_rst_wready", wready, 1);
      chk("post_rst_arready", arready, 1);

      // Same-cycle AW+W
      do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      chk("reg2_const", reg_out[2*32 +: 32], 32'hDEADBEEF);

      // AW three cycles ahead of W, partial strobe
      do_write(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
      do_write(32'h04, 32'h12345678, 4'h3, 0, 3, 0);
      chk("reg1_const", reg_out[1*32 +: 32], 32'hAABB5678);

      // Back-pressure on B for five cycles
      do_write(32'h0C, 32'h00000055, 4'hF, 0, 0, 5);

      // W ahead of AW, and an all-zero strobe
      do_write(32'h30, 32'h0BADF00D, 4'hF, 2, 0, 1);
      do_write(32'h08, 32'hFFFFFFFF, 4'h0, 1, 0, 0);
      chk("strb0_nochange", reg_out[2*32 +: 32], 32'hDEADBEEF);

      // Read and write to the same register on the same edge
      awaddr = 32'h08; wdata = 32'h11111111; wstrb = 4'hF;
      araddr = 32'h08;
      awvalid = 1; wvalid = 1; arvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      chk("rw_rvalid", rvalid, 1);
      chk("rw_rdata_old", rdata, 32'hDEADBEEF);
      chk("rw_bvalid", bvalid, 1);
      model[2] = 32'h11111111;
      chk("rw_reg_new", reg_out[2*32 +: 32], model[2]);
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      do_read(32'h08, 0, 0);
      chk("rw_reg2_const", model[2], 32'h11111111);

      // Beyond the register window
      do_write(32'h100, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      do_read(32'h100, 0, 0);
      do_read(32'h00, 1, 2);

      // Randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         a = {$urandom_range(0, 15), 2'($urandom)} & 32'h3F;
         if ($urandom_range(0, 3) == 0) a = a | ($urandom() << 6);
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom(), 4'($urandom()), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2));
         else
            do_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
      end
      for (int i = 0; i < 16; i++)
         chk($sformatf("final_reg%0d", i), reg_out[i*32 +: 32], model[i]);

      // Reset while both responses are pending
      awaddr = 32'h0C; wdata = 32'h77777777; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      araddr = 32'h0C; arvalid = 1;
      tick();
      arvalid = 0;
      chk("pend_bvalid", bvalid, 1);
      chk("pend_rvalid", rvalid, 1);
      areset = 1'b1;
      #1;
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_rvalid", rvalid, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_readies", {awready, wready, arready}, 0);
      chk("mid_rst_regs", reg_out == '0, 1);
      for (int i = 0; i < 16; i++) model[i] = '0;
      tick();
      areset = 1'b0;
      bready = 1; rready = 1;
      repeat (3) begin
         tick();
         chk("no_stale_b", bvalid, 0);
         chk("no_stale_r", rvalid, 0);
      end
      bready = 0; rready = 0;
      do_read(32'h0C, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
